// File: rtl/arbitro_pkg.sv
// arbitro_pkg: shared definitions for the round-robin arbiter/sequencer.
//   - one-hot FSM state encoding
//   - default word and counter widths
//   - destination field position, given as offsets from the word MSB
package arbitro_pkg;

  localparam int DATA_W_DEF  = 10;
  localparam int CNT_W_DEF   = 8;
  localparam int NUM_PORTS   = 4;
  // Destination field is [DATA_W-DEST_HI_OFS : DATA_W-DEST_LO_OFS]
  localparam int DEST_HI_OFS = 1;
  localparam int DEST_LO_OFS = 2;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_POP  = 4'b0010,
    ST_CAPT = 4'b0100,
    ST_PUSH = 4'b1000
  } state_t;

  function automatic logic [1:0] inc2(input logic [1:0] v);
    return v + 2'd1;
  endfunction

endpackage

// File: rtl/arbitro_rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker.
//   i_req[3:0]  request vector (1 = source has data)
//   i_ptr[1:0]  highest-priority index; scan runs upward modulo 4
//   o_gnt_idx   first requesting index found from i_ptr
//   o_any       any request present (o_gnt_idx meaningless when low)
module rr_pick4
  import arbitro_pkg::*;
(
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_gnt_idx,
  output logic       o_any
);

  logic       w_found;
  logic [1:0] w_idx;

  always_comb begin
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = i_ptr;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_idx = i_ptr + 2'(i);
      if (!w_found && i_req[w_idx]) begin
        o_gnt_idx = w_idx;
        w_found   = 1'b1;
      end
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/arbitro_rr.sv
// arbitro_rr: round-robin transfer sequencer, input FIFOs 0..3 -> output FIFOs 4..7.
// One word per transfer: POP the granted input, CAPT the word from the demux
// path, PUSH it to the output FIFO named by its top two bits.
//   clk, reset        clock, synchronous active-high reset
//   empty0..3         input FIFO empty flags
//   full4..7          output FIFO full flags (only the destination's is used)
//   dato_inter        word from the demux, valid the cycle after pop
//   pop0..3, push4..7 single-cycle strobes
//   demux             granted source index
//   dato_out          hold register, shared by all output FIFOs
//   busy              FSM not in IDLE
//   cnt4..7           words pushed per output FIFO, wrapping
module arbitro_rr
  import arbitro_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              empty0,
  input  logic              empty1,
  input  logic              empty2,
  input  logic              empty3,
  input  logic              full4,
  input  logic              full5,
  input  logic              full6,
  input  logic              full7,
  input  logic [DATA_W-1:0] dato_inter,
  output logic              pop0,
  output logic              pop1,
  output logic              pop2,
  output logic              pop3,
  output logic              push4,
  output logic              push5,
  output logic              push6,
  output logic              push7,
  output logic [1:0]        demux,
  output logic [DATA_W-1:0] dato_out,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt4,
  output logic [CNT_W-1:0]  cnt5,
  output logic [CNT_W-1:0]  cnt6,
  output logic [CNT_W-1:0]  cnt7
);

  localparam int DEST_HI = DATA_W - DEST_HI_OFS;
  localparam int DEST_LO = DATA_W - DEST_LO_OFS;

  state_t            r_state, w_state_nxt;
  logic [1:0]        r_grant, r_dest, r_rr_ptr;
  logic [DATA_W-1:0] r_hold;
  logic [CNT_W-1:0]  r_cnt [NUM_PORTS];

  logic [3:0] w_req, w_full, w_pop, w_push;
  logic [1:0] w_pick;
  logic       w_any, w_load_grant, w_dest_full;

  assign w_req       = ~{empty3, empty2, empty1, empty0};
  assign w_full      = {full7, full6, full5, full4};
  assign w_dest_full = w_full[r_dest];

  // One picker serves both the IDLE and the PUSH->POP grant decisions;
  // rr_ptr is already advanced in CAPT, so PUSH sees the updated priority.
  rr_pick4 u_pick (
    .i_req     (w_req),
    .i_ptr     (r_rr_ptr),
    .o_gnt_idx (w_pick),
    .o_any     (w_any)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = '0;
    w_push       = '0;
    w_load_grant = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_load_grant = 1'b1;
          w_state_nxt  = ST_POP;
        end
      end
      ST_POP: begin
        w_pop[r_grant] = 1'b1;
        w_state_nxt    = ST_CAPT;
      end
      ST_CAPT: w_state_nxt = ST_PUSH;
      ST_PUSH: begin
        // A full destination holds the word here; other outputs are irrelevant.
        if (!w_dest_full) begin
          w_push[r_dest] = 1'b1;
          if (w_any) begin
            w_load_grant = 1'b1;
            w_state_nxt  = ST_POP;
          end else begin
            w_state_nxt  = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_dest   <= '0;
      r_rr_ptr <= '0;
      r_hold   <= '0;
      for (int i = 0; i < NUM_PORTS; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_grant) r_grant <= w_pick;
      if (r_state == ST_CAPT) begin
        r_hold   <= dato_inter;
        r_dest   <= dato_inter[DEST_HI:DEST_LO];
        r_rr_ptr <= inc2(r_grant);
      end
      for (int i = 0; i < NUM_PORTS; i++)
        if (w_push[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
    end
  end

  assign {pop3, pop2, pop1, pop0}     = w_pop;
  assign {push7, push6, push5, push4} = w_push;
  assign demux    = r_grant;
  assign dato_out = r_hold;
  assign busy     = (r_state != ST_IDLE);
  assign cnt4     = r_cnt[0];
  assign cnt5     = r_cnt[1];
  assign cnt6     = r_cnt[2];
  assign cnt7     = r_cnt[3];

endmodule
